mold_seq_tracker: RTL and testbench
===================================

# mold_seq_tracker

Per-session MoldUDP64 sequence tracker and session-table arbiter, sitting beside the Ethernet/UDP parser in the market-data ingress path. It consumes one header summary per accepted frame: session index, sequence number and message count. It flags in-order, duplicate/stale and gapped packets, and emits retransmission (gap) requests. It also shares the session table between the parser (priority) and a host configuration port (read/seed expected sequence numbers).

## Interface
- NUM_SESSIONS, 32: session table depth
- IDX_W, 5: session index width, $clog2(NUM_SESSIONS)
- SEQ_W, 64: sequence number width
- clkIn  in  1  sole clock
- rstNIn  in  1  asynchronous, active-low reset
- hdrValidIn  in  1  one-cycle pulse, header summary valid
- sessIdxIn  in  IDX_W  session table index
- seqNumIn  in  SEQ_W  MoldUDP64 sequence number of first message
- msgCntIn  in  16  message count (0 = heartbeat, 16'hFFFF = end of session)
- cfgReqIn  in  1  host request, level, held until cfgAckOut
- cfgWrIn  in  1  1 = write, 0 = read; stable while cfgReqIn high
- cfgIdxIn  in  IDX_W  host session index
- cfgDataIn  in  SEQ_W  expected sequence to seed
- cfgAckOut  out  1  one-cycle completion pulse
- cfgRdDataOut  out  SEQ_W  read data, valid with cfgAckOut
- cfgRdValidOut  out  1  entry-valid bit, valid with cfgAckOut
- inOrderOut  out  1  pulse: packet accepted in order (or first of session)
- dupOut  out  1  pulse: seq < expected, table unchanged
- gapValidOut  out  1  pulse: gap detected, retransmit request
- gapSessOut  out  IDX_W  gap session
- gapStartOut  out  SEQ_W  first missing sequence number
- gapCntOut  out  16  missing count, saturated at 16'hFFFF
- hdrDropOut  out  1  pulse: hdrValidIn arrived while not IDLE, ignored

## Operation
- Each table entry holds expected[SEQ_W-1:0] plus a valid bit. Valid bits are flops cleared by reset; expected values are RAM and are not cleared.
- FSM states: IDLE, HDR_RD, HDR_UPD, CFG_RD, CFG_DONE.
- In IDLE, hdrValidIn goes to HDR_RD and the inputs are latched. If cfgReqIn is also high, the header wins and cfg waits.
- In IDLE, cfgReqIn alone goes to CFG_RD.
- HDR_RD registers the table read, then moves to HDR_UPD.
- HDR_UPD decides, writes back, pulses outputs, then returns to IDLE.
- CFG_RD reads or writes, then moves to CFG_DONE.
- CFG_DONE pulses cfgAckOut and returns to IDLE. cfgReqIn must drop the cycle after ack; if it is still high, a new request is served.
- HDR_UPD decision rules, in priority order (all sequence arithmetic is modulo 2^SEQ_W):
  - Entry invalid: inOrderOut; expected = seq+cnt; valid = 1.
  - seq == expected: inOrderOut; expected += cnt.
  - seq > expected: gapValidOut with gapStartOut = expected and gapCntOut = min(seq−expected, 16'hFFFF); expected = seq+cnt.
  - seq < expected: dupOut; no write.
- msgCnt 16'hFFFF (end of session): classify as above, treating cnt as 0, then clear the valid bit.
- msgCnt 0 (heartbeat): same rules with cnt = 0, so a heartbeat can reveal a gap.
- Config write: expected = cfgDataIn, valid = 1.
- Config read: returns the entry and its valid bit; the table is unchanged.

## Timing
- Reset asserted (asynchronous): FSM goes to IDLE, valid bits and all outputs go to 0, and any in-flight header or cfg is abandoned with no ack.
- Header latency: hdrValidIn sampled at edge E0 produces exactly one result pulse (inOrderOut, dupOut or gapValidOut) for one cycle after E2. The table write lands at E2.
- Gap output fields are held until the next gap pulse.
- Minimum header spacing is 3 cycles; real frames are ≥64 bytes apart. An earlier header is dropped with hdrDropOut the following cycle.
- Cfg latency: request accepted at edge E0 in IDLE, cfgAckOut high for one cycle after E2.
- Worst-case cfg wait is one header service (3 cycles).
- No forwarding is needed: one operation is in flight at a time.

## Structure
- Shared package holds:
  - MOLD_END_OF_SESSION = 16'hFFFF
  - MOLD_HEARTBEAT = 16'h0000
  - seqTrackStateType enum
  - seqEntryType struct {valid, expected}
- Sub-module seq_table_ram: single-port, synchronous-read, NUM_SESSIONS×SEQ_W distributed RAM.
- The FSM, arbitration, compare/subtract/saturation logic and valid flops live in mold_seq_tracker.

## Test plan
- Session 3, first header seq=100 cnt=5, then seq=105 cnt=2 → inOrderOut twice; cfg read of index 3 returns 107, valid=1.
- Expected 107, header seq=110 cnt=1 → gapValidOut with gapSessOut=3, gapStartOut=107, gapCntOut=3; expected becomes 111.
- Expected 111, header seq=50 cnt=4 → dupOut only; cfg read still returns 111. Then seq=111 cnt=16'hFFFF → inOrderOut; valid cleared.
- Expected 0, header seq=2^40 cnt=1 → gapCntOut=16'hFFFF. Expected 2^64−1, seq=2^64−1 cnt=2 → inOrderOut; expected wraps to 1.
- cfgReqIn write idx 7 data 500 asserted the same cycle as hdrValidIn idx 7 seq=9 → header served first (inOrderOut); the cfg ack follows; a subsequent read returns 500.
- hdrValidIn pulsed on 2 consecutive cycles → second pulse gives hdrDropOut. rstNIn asserted during HDR_RD → no result pulse and all valid bits clear.

Source files
------------

// File: rtl/mold_seq_tracker_pkg.sv
// Shared types and constants for the MoldUDP64 per-session sequence tracker.
package mold_seq_tracker_pkg;

    localparam int          MOLD_SEQ_W          = 64;
    localparam logic [15:0] MOLD_END_OF_SESSION = 16'hFFFF;
    localparam logic [15:0] MOLD_HEARTBEAT      = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_UPD,
        CFG_RD,
        CFG_DONE
    } seqTrackStateType;

    typedef struct packed {
        logic                  valid;
        logic [MOLD_SEQ_W-1:0] expected;
    } seqEntryType;

endpackage

// File: rtl/mold_seq_tracker_seq_table_ram.sv
// Single-port synchronous-read session table holding expected sequence numbers.
module seq_table_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are not reset; the tracker's valid flops gate their use.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mold_seq_tracker.sv
// Per-session MoldUDP64 sequence tracker: classifies headers (in-order/dup/gap)
// and shares the session table with a host config port (parser has priority).
module mold_seq_tracker
    import mold_seq_tracker_pkg::*;
#(
    parameter int NUM_SESSIONS = 32,
    parameter int IDX_W        = 5,
    parameter int SEQ_W        = 64
) (
    input  logic             clkIn,
    input  logic             rstNIn,
    input  logic             hdrValidIn,
    input  logic [IDX_W-1:0] sessIdxIn,
    input  logic [SEQ_W-1:0] seqNumIn,
    input  logic [15:0]      msgCntIn,
    input  logic             cfgReqIn,
    input  logic             cfgWrIn,
    input  logic [IDX_W-1:0] cfgIdxIn,
    input  logic [SEQ_W-1:0] cfgDataIn,
    output logic             cfgAckOut,
    output logic [SEQ_W-1:0] cfgRdDataOut,
    output logic             cfgRdValidOut,
    output logic             inOrderOut,
    output logic             dupOut,
    output logic             gapValidOut,
    output logic [IDX_W-1:0] gapSessOut,
    output logic [SEQ_W-1:0] gapStartOut,
    output logic [15:0]      gapCntOut,
    output logic             hdrDropOut
);

    seqTrackStateType state, state_nxt;

    logic [NUM_SESSIONS-1:0] valid_q;
    logic [IDX_W-1:0]        hdr_idx;
    logic [SEQ_W-1:0]        hdr_seq;
    logic [15:0]             hdr_cnt;

    logic                    ram_we;
    logic [IDX_W-1:0]        ram_addr;
    logic [SEQ_W-1:0]        ram_wdata;
    logic [SEQ_W-1:0]        ram_rdata;

    seqEntryType             cur;
    logic                    is_eos;
    logic [15:0]             cnt_eff;
    logic [SEQ_W-1:0]        seq_sum;
    logic [SEQ_W-1:0]        diff;
    logic [15:0]             gap_sat;

    logic                    hdr_load;
    logic                    res_in_order, res_dup, res_gap;
    logic                    vld_wr;
    logic [IDX_W-1:0]        vld_idx;
    logic                    vld_val;

    seq_table_ram #(.DEPTH(NUM_SESSIONS), .AW(IDX_W), .DW(SEQ_W)) u_table (
        .clk   (clkIn),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // End-of-session is classified like a heartbeat, then retires the entry.
    assign is_eos       = (hdr_cnt == MOLD_END_OF_SESSION);
    assign cnt_eff      = is_eos ? MOLD_HEARTBEAT : hdr_cnt;
    assign seq_sum      = hdr_seq + {{(SEQ_W-16){1'b0}}, cnt_eff};
    assign cur.valid    = valid_q[hdr_idx];
    assign cur.expected = ram_rdata;
    assign diff         = hdr_seq - cur.expected;
    assign gap_sat      = (|diff[SEQ_W-1:16]) ? 16'hFFFF : diff[15:0];

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        hdr_load     = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = hdr_idx;
        ram_wdata    = seq_sum;
        res_in_order = 1'b0;
        res_dup      = 1'b0;
        res_gap      = 1'b0;
        vld_wr       = 1'b0;
        vld_idx      = hdr_idx;
        vld_val      = 1'b0;
        case (state)
            IDLE: begin
                if (hdrValidIn) begin
                    hdr_load  = 1'b1;
                    state_nxt = HDR_RD;
                end else if (cfgReqIn) begin
                    state_nxt = CFG_RD;
                end
            end
            HDR_RD: state_nxt = HDR_UPD;
            HDR_UPD: begin
                state_nxt = IDLE;
                if (!cur.valid || hdr_seq == cur.expected) begin
                    res_in_order = 1'b1;
                    ram_we       = 1'b1;
                    vld_wr       = 1'b1;
                    vld_val      = 1'b1;
                end else if (hdr_seq > cur.expected) begin
                    res_gap = 1'b1;
                    ram_we  = 1'b1;
                end else begin
                    res_dup = 1'b1;
                end
                if (is_eos) begin
                    vld_wr  = 1'b1;
                    vld_val = 1'b0;
                end
            end
            CFG_RD: begin
                state_nxt = CFG_DONE;
                ram_addr  = cfgIdxIn;
                ram_we    = cfgWrIn;
                ram_wdata = cfgDataIn;
                vld_wr    = cfgWrIn;
                vld_idx   = cfgIdxIn;
                vld_val   = 1'b1;
            end
            CFG_DONE: begin
                state_nxt = IDLE;
                ram_addr  = cfgIdxIn;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (hdr_load) begin
            hdr_idx <= sessIdxIn;
            hdr_seq <= seqNumIn;
            hdr_cnt <= msgCntIn;
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) valid_q <= '0;
        else if (vld_wr) valid_q[vld_idx] <= vld_val;
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            inOrderOut    <= 1'b0;
            dupOut        <= 1'b0;
            gapValidOut   <= 1'b0;
            gapSessOut    <= '0;
            gapStartOut   <= '0;
            gapCntOut     <= '0;
            hdrDropOut    <= 1'b0;
            cfgAckOut     <= 1'b0;
            cfgRdDataOut  <= '0;
            cfgRdValidOut <= 1'b0;
        end else begin
            inOrderOut  <= res_in_order;
            dupOut      <= res_dup;
            gapValidOut <= res_gap;
            hdrDropOut  <= hdrValidIn && (state != IDLE);
            cfgAckOut   <= (state == CFG_DONE);
            // Gap fields persist until the next gap so the host can poll them.
            if (res_gap) begin
                gapSessOut  <= hdr_idx;
                gapStartOut <= cur.expected;
                gapCntOut   <= gap_sat;
            end
            if (state == CFG_DONE) begin
                cfgRdDataOut  <= ram_rdata;
                cfgRdValidOut <= valid_q[cfgIdxIn];
            end
        end
    end

endmodule

// File: tb/tb_mold_seq_tracker.sv
// Directed scoreboard bench for mold_seq_tracker: header results are queued at
// drive time and popped when a result pulse appears.
module tb_mold_seq_tracker;

    logic        clkIn = 1'b0;
    logic        rstNIn;
    logic        hdrValidIn;
    logic [4:0]  sessIdxIn;
    logic [63:0] seqNumIn;
    logic [15:0] msgCntIn;
    logic        cfgReqIn;
    logic        cfgWrIn;
    logic [4:0]  cfgIdxIn;
    logic [63:0] cfgDataIn;
    logic        cfgAckOut;
    logic [63:0] cfgRdDataOut;
    logic        cfgRdValidOut;
    logic        inOrderOut;
    logic        dupOut;
    logic        gapValidOut;
    logic [4:0]  gapSessOut;
    logic [63:0] gapStartOut;
    logic [15:0] gapCntOut;
    logic        hdrDropOut;

    localparam logic [2:0] K_IN  = 3'b001;
    localparam logic [2:0] K_DUP = 3'b010;
    localparam logic [2:0] K_GAP = 3'b100;

    typedef struct {
        string       tag;
        logic [2:0]  kind;
        logic [4:0]  sess;
        logic [63:0] start;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    mold_seq_tracker dut (
        .clkIn(clkIn), .rstNIn(rstNIn), .hdrValidIn(hdrValidIn),
        .sessIdxIn(sessIdxIn), .seqNumIn(seqNumIn), .msgCntIn(msgCntIn),
        .cfgReqIn(cfgReqIn), .cfgWrIn(cfgWrIn), .cfgIdxIn(cfgIdxIn),
        .cfgDataIn(cfgDataIn), .cfgAckOut(cfgAckOut), .cfgRdDataOut(cfgRdDataOut),
        .cfgRdValidOut(cfgRdValidOut), .inOrderOut(inOrderOut), .dupOut(dupOut),
        .gapValidOut(gapValidOut), .gapSessOut(gapSessOut), .gapStartOut(gapStartOut),
        .gapCntOut(gapCntOut), .hdrDropOut(hdrDropOut)
    );

    always #5 clkIn = ~clkIn;

    function automatic logic [2:0] res_kind();
        return {gapValidOut, dupOut, inOrderOut};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] kind, input logic [4:0] sess,
                        input logic [63:0] start, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.kind = kind; e.sess = sess; e.start = start; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic pop_result(input int lat);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_result", {61'd0, res_kind()}, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_kind"}, {61'd0, res_kind()}, {61'd0, e.kind});
            chk({e.tag, "_lat"}, lat, 2);
            if (e.kind == K_GAP) begin
                chk({e.tag, "_gsess"}, {59'd0, gapSessOut}, {59'd0, e.sess});
                chk({e.tag, "_gstart"}, gapStartOut, e.start);
                chk({e.tag, "_gcnt"}, {48'd0, gapCntOut}, {48'd0, e.cnt});
            end
        end
    endtask

    task automatic wait_result(input string tag, input int start_c);
        bit found = 0;
        for (int c = start_c; c <= 8 && !found; c++) begin
            @(negedge clkIn);
            if (res_kind() != 3'b000) begin
                found = 1;
                pop_result(c);
            end
        end
        if (!found) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic send_hdr(input string tag, input logic [4:0] idx, input logic [63:0] seq,
                            input logic [15:0] cnt, input logic [2:0] kind,
                            input logic [63:0] gstart, input logic [15:0] gcnt);
        push(tag, kind, idx, gstart, gcnt);
        @(negedge clkIn);
        hdrValidIn = 1'b1; sessIdxIn = idx; seqNumIn = seq; msgCntIn = cnt;
        @(negedge clkIn);
        hdrValidIn = 1'b0;
        wait_result(tag, 1);
    endtask

    task automatic cfg_op(input string tag, input logic wr, input logic [4:0] idx,
                          input logic [63:0] data, input logic [63:0] exp_data,
                          input logic exp_valid, input bit chk_data);
        bit found = 0;
        @(negedge clkIn);
        cfgReqIn = 1'b1; cfgWrIn = wr; cfgIdxIn = idx; cfgDataIn = data;
        for (int c = 1; c <= 8 && !found; c++) begin
            @(negedge clkIn);
            if (cfgAckOut) begin
                found = 1;
                cfgReqIn = 1'b0;
                chk({tag, "_lat"}, c, 3);
                if (!wr) begin
                    if (chk_data) chk({tag, "_data"}, cfgRdDataOut, exp_data);
                    chk({tag, "_valid"}, {63'd0, cfgRdValidOut}, {63'd0, exp_valid});
                end
            end
        end
        if (!found) begin
            cfgReqIn = 1'b0;
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end
    endtask

    initial begin
        int ack_c;
        rstNIn = 1'b0; hdrValidIn = 1'b0; sessIdxIn = '0; seqNumIn = '0; msgCntIn = '0;
        cfgReqIn = 1'b0; cfgWrIn = 1'b0; cfgIdxIn = '0; cfgDataIn = '0;
        repeat (3) @(posedge clkIn);
        @(negedge clkIn);
        chk("rst_inorder", {63'd0, inOrderOut}, 64'd0);
        chk("rst_dup",     {63'd0, dupOut}, 64'd0);
        chk("rst_gap",     {63'd0, gapValidOut}, 64'd0);
        chk("rst_ack",     {63'd0, cfgAckOut}, 64'd0);
        chk("rst_drop",    {63'd0, hdrDropOut}, 64'd0);
        chk("rst_gcnt",    {48'd0, gapCntOut}, 64'd0);
        rstNIn = 1'b1;

        // In-order stream on session 3, gap, duplicate, end of session
        send_hdr("s3_first", 5'd3, 64'd100, 16'd5, K_IN, 0, 0);
        send_hdr("s3_next",  5'd3, 64'd105, 16'd2, K_IN, 0, 0);
        cfg_op("rd3_a", 1'b0, 5'd3, 0, 64'd107, 1'b1, 1);
        send_hdr("s3_gap",   5'd3, 64'd110, 16'd1, K_GAP, 64'd107, 16'd3);
        cfg_op("rd3_b", 1'b0, 5'd3, 0, 64'd111, 1'b1, 1);
        send_hdr("s3_dup",   5'd3, 64'd50, 16'd4, K_DUP, 0, 0);
        cfg_op("rd3_c", 1'b0, 5'd3, 0, 64'd111, 1'b1, 1);
        send_hdr("s3_eos",   5'd3, 64'd111, 16'hFFFF, K_IN, 0, 0);
        cfg_op("rd3_d", 1'b0, 5'd3, 0, 64'd111, 1'b0, 1);
        send_hdr("s3_reopen", 5'd3, 64'd7, 16'd1, K_IN, 0, 0);

        // Heartbeat reveals a gap; gap fields held across a later in-order pulse
        send_hdr("s8_first", 5'd8, 64'd20, 16'd3, K_IN, 0, 0);
        send_hdr("s8_hb",    5'd8, 64'd25, 16'd0, K_GAP, 64'd23, 16'd2);
        send_hdr("s8_next",  5'd8, 64'd25, 16'd1, K_IN, 0, 0);
        chk("gap_hold_start", gapStartOut, 64'd23);
        chk("gap_hold_cnt", {48'd0, gapCntOut}, 64'd2);

        // Saturated gap count and 64-bit wrap
        cfg_op("wr5", 1'b1, 5'd5, 64'd0, 0, 1'b0, 0);
        send_hdr("s5_sat", 5'd5, 64'h0000_0100_0000_0000, 16'd1, K_GAP, 64'd0, 16'hFFFF);
        cfg_op("rd5", 1'b0, 5'd5, 0, 64'h0000_0100_0000_0001, 1'b1, 1);
        cfg_op("wr6", 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 0);
        send_hdr("s6_wrap", 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, K_IN, 0, 0);
        cfg_op("rd6", 1'b0, 5'd6, 0, 64'd1, 1'b1, 1);

        // Header and cfg request in the same cycle: header first, ack afterwards
        push("s7_conc", K_IN, 5'd7, 0, 0);
        @(negedge clkIn);
        hdrValidIn = 1'b1; sessIdxIn = 5'd7; seqNumIn = 64'd9; msgCntIn = 16'd1;
        cfgReqIn = 1'b1; cfgWrIn = 1'b1; cfgIdxIn = 5'd7; cfgDataIn = 64'd500;
        @(negedge clkIn);
        hdrValidIn = 1'b0;
        ack_c = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clkIn);
            if (res_kind() != 3'b000) pop_result(c);
            if (cfgAckOut && ack_c == 0) begin
                ack_c = c;
                cfgReqIn = 1'b0; cfgWrIn = 1'b0;
            end
        end
        cfgReqIn = 1'b0;
        chk("conc_ack_lat", ack_c, 5);
        cfg_op("rd7", 1'b0, 5'd7, 0, 64'd500, 1'b1, 1);

        // Back-to-back header pulses: second is dropped
        push("s10_b2b", K_IN, 5'd10, 0, 0);
        @(negedge clkIn);
        hdrValidIn = 1'b1; sessIdxIn = 5'd10; seqNumIn = 64'd1; msgCntIn = 16'd1;
        @(negedge clkIn);
        @(negedge clkIn);
        hdrValidIn = 1'b0;
        chk("b2b_drop", {63'd0, hdrDropOut}, 64'd1);
        wait_result("s10_b2b", 2);
        chk("b2b_drop_clr", {63'd0, hdrDropOut}, 64'd0);

        // Reset while a header is in HDR_RD: no result, valid bits cleared
        @(negedge clkIn);
        hdrValidIn = 1'b1; sessIdxIn = 5'd7; seqNumIn = 64'd10; msgCntIn = 16'd1;
        @(negedge clkIn);
        hdrValidIn = 1'b0;
        rstNIn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clkIn);
            chk("rst_no_result", {61'd0, res_kind()}, 64'd0);
        end
        rstNIn = 1'b1;
        @(negedge clkIn);
        chk("rst_no_result_post", {61'd0, res_kind()}, 64'd0);
        cfg_op("rst_rd7",  1'b0, 5'd7,  0, 0, 1'b0, 0);
        cfg_op("rst_rd10", 1'b0, 5'd10, 0, 0, 1'b0, 0);
        cfg_op("rst_rd6",  1'b0, 5'd6,  0, 0, 1'b0, 0);
        send_hdr("s7_after_rst", 5'd7, 64'd42, 16'd1, K_IN, 0, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
